// File: rtl/bsg_and_rr_sched_pkg.sv
// Shared helpers for the bsg_and_rr_sched block.
// Contents: safe_clog2() gives an index width of at least one bit, so a
// single-requester build still has a legal id port.
package bsg_and_rr_sched_pkg;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_and.sv
// Bitwise AND primitive.
// Ports: a_i, b_i - width_p-bit operands; o - a_i & b_i.
module bsg_and #(
  parameter int unsigned width_p = 1
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic [width_p-1:0] o
);

  assign o = a_i & b_i;

endmodule

// File: rtl/bsg_and_rr_sched_arb.sv
// Combinational round-robin pick.
// Ports: req_i - per-requester request; last_i - index of the previous winner;
// en_i - allow a grant this cycle; grant_o - one-hot grant; id_o - encoded winner.
// The search starts at last_i+1 and wraps, so the previous winner gets the lowest
// priority.
module bsg_and_rr_sched_arb
  import bsg_and_rr_sched_pkg::*;
#(
  parameter  int unsigned els_p     = 4,
  localparam int unsigned lg_els_lp = safe_clog2(els_p)
) (
  input  logic [els_p-1:0]     req_i,
  input  logic [lg_els_lp-1:0] last_i,
  input  logic                 en_i,
  output logic [els_p-1:0]     grant_o,
  output logic [lg_els_lp-1:0] id_o
);

  always_comb begin
    logic                 found;
    logic [lg_els_lp-1:0] sel;
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    sel     = '0;
    for (int unsigned off = 1; off <= els_p; off++) begin
      sel = lg_els_lp'((32'(last_i) + off) % els_p);
      if (en_i && !found && req_i[sel]) begin
        grant_o[sel] = 1'b1;
        id_o         = sel;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_and_rr_sched.sv
// Round-robin scheduler sharing one bsg_and datapath among els_p requesters.
// Ports:
//   clk_i, reset_n_i  - clock, synchronous active-low reset
//   v_i, a_i, b_i     - per-requester valid and packed operands (k at [k*width_p +: width_p])
//   yumi_o            - one-hot grant; the granted operands are consumed this cycle
//   v_o, data_o, id_o - registered AND result and the id of the requester it came from
//   yumi_i            - consumer takes the result this cycle
module bsg_and_rr_sched
  import bsg_and_rr_sched_pkg::*;
#(
  parameter  int unsigned width_p   = 16,
  parameter  int unsigned els_p     = 4,
  localparam int unsigned lg_els_lp = safe_clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   a_i,
  input  logic [els_p*width_p-1:0]   b_i,
  output logic [els_p-1:0]           yumi_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [lg_els_lp-1:0]       id_o,
  input  logic                       yumi_i
);

  logic                 v_q, v_d;
  logic [width_p-1:0]   data_q, data_d;
  logic [lg_els_lp-1:0] id_q, id_d;
  logic [lg_els_lp-1:0] last_q, last_d;

  logic                 acc;
  logic [els_p-1:0]     grant;
  logic [lg_els_lp-1:0] grant_id;
  logic [width_p-1:0]   a_sel, b_sel, and_out;

  // Accept when empty or being drained this cycle; yumi_i on an empty register is ignored
  // because ~v_q already enables acceptance.
  assign acc = ~v_q | yumi_i;

  bsg_and_rr_sched_arb #(
    .els_p (els_p)
  ) u_arb (
    .req_i   (v_i),
    .last_i  (last_q),
    .en_i    (acc & reset_n_i),
    .grant_o (grant),
    .id_o    (grant_id)
  );

  // One-hot AND-OR mux of the granted operand pair.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < int'(els_p); k++) begin
      a_sel |= {width_p{grant[k]}} & a_i[k*width_p +: width_p];
      b_sel |= {width_p{grant[k]}} & b_i[k*width_p +: width_p];
    end
  end

  bsg_and #(
    .width_p (width_p)
  ) u_and (
    .a_i (a_sel),
    .b_i (b_sel),
    .o   (and_out)
  );

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    id_d   = id_q;
    last_d = last_q;
    if (|grant) begin
      v_d    = 1'b1;
      data_d = and_out;
      id_d   = grant_id;
      last_d = grant_id;
    end else if (v_q && yumi_i) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
      last_q <= lg_els_lp'(els_p - 1);
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      id_q   <= id_d;
      last_q <= last_d;
    end
  end

  assign yumi_o = grant;
  assign v_o    = v_q;
  assign data_o = data_q;
  assign id_o   = id_q;

endmodule

// File: tb/tb_bsg_and_rr_sched.sv
module tb_bsg_and_rr_sched;

  localparam int W = 16;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset_n_i = 1'b0;
  logic [N-1:0]     v_i = '0;
  logic [N*W-1:0]   a_i = '0;
  logic [N*W-1:0]   b_i = '0;
  logic             yumi_i = 1'b0;
  logic [N-1:0]     yumi_o;
  logic             v_o;
  logic [W-1:0]     data_o;
  logic [1:0]       id_o;

  bsg_and_rr_sched #(
    .width_p (W),
    .els_p   (N)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .yumi_o    (yumi_o),
    .v_o       (v_o),
    .data_o    (data_o),
    .id_o      (id_o),
    .yumi_i    (yumi_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   id;
  } res_t;

  res_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  bit           started = 0;
  bit           m_valid = 0;
  int           order[$];
  logic [N-1:0] m_gnt = '0;
  logic [N-1:0] cur_v = '0;
  logic [W-1:0] opa[N];
  logic [W-1:0] opb[N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: priority is a rotating list of requester ids; the winner is
  // the first valid id in the list, after which the list rotates to start just past it.
  always @(negedge clk) begin
    int           k;
    logic [N-1:0] exp_g;
    res_t         r;
    exp_g = '0;
    k = -1;
    if (reset_n_i && (!m_valid || yumi_i))
      foreach (order[i]) if (k < 0 && v_i[order[i]]) k = order[i];
    if (k >= 0) exp_g[k] = 1'b1;
    chk("yumi_o", 32'(yumi_o), 32'(exp_g));
    #1;
    if (!reset_n_i) begin
      m_valid = 0;
      sb.delete();
      order = '{0, 1, 2, 3};
      m_gnt = '0;
    end else begin
      if (k >= 0) begin
        r.data = opa[k] & opb[k];
        r.id   = k[1:0];
        sb.push_back(r);
        m_valid = 1;
        while (order[0] != k) order.push_back(order.pop_front());
        order.push_back(order.pop_front());
      end else if (yumi_i) begin
        m_valid = 0;
      end
      m_gnt = exp_g;
    end
  end

  // Monitor: compares the presented result against the scoreboard head.
  always @(negedge clk) begin
    if (started) begin
      chk("v_o", 32'(v_o), 32'(sb.size() != 0));
      if (yumi_i) chk("yumi_i_legal", 32'(v_o), 32'(1));
      if (v_o && sb.size() != 0) begin
        chk("data_o", 32'(data_o), 32'(sb[0].data));
        chk("id_o", 32'(id_o), 32'(sb[0].id));
        if (yumi_i) void'(sb.pop_front());
      end
    end
  end

  // Requesters hold valid and operands until granted.
  task automatic drive(input logic [N-1:0] want, input bit y, input bit rst, input bit rnd);
    @(posedge clk);
    #1;
    reset_n_i = !rst;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        cur_v[k] = 1'b0;
      end else if (!(cur_v[k] && !m_gnt[k])) begin
        cur_v[k] = want[k];
        if (rnd && want[k]) begin
          opa[k] = W'($urandom);
          opb[k] = W'($urandom);
        end
      end
      a_i[k*W +: W] = opa[k];
      b_i[k*W +: W] = opb[k];
    end
    v_i    = cur_v;
    yumi_i = y && m_valid && !rst;
  endtask

  task automatic flush();
    repeat (8) drive('0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      opa[k] = '0;
      opb[k] = '0;
    end
    order = '{0, 1, 2, 3};
    @(posedge clk);
    #1 started = 1;
    drive('0, 1'b0, 1'b1, 1'b0);

    // 1: idle after reset
    repeat (5) begin
      drive('0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("t1_v_o", 32'(v_o), 32'(0));
      chk("t1_data_o", 32'(data_o), 32'(0));
      chk("t1_id_o", 32'(id_o), 32'(0));
      chk("t1_yumi_o", 32'(yumi_o), 32'(0));
    end

    // 2: single request
    opa[2] = 16'hF0F0;
    opb[2] = 16'h3C3C;
    drive(4'b0100, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_gnt", 32'(yumi_o), 32'(4'b0100));
    drive('0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_v_o", 32'(v_o), 32'(1));
    chk("t2_data_o", 32'(data_o), 32'(16'h3030));
    chk("t2_id_o", 32'(id_o), 32'(2));

    // 3: all valid, full throughput; last winner was 2
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("t3_gnt", 32'(yumi_o), 32'(4'b0001 << ((3 + i) % 4)));
      if (i > 0) chk("t3_no_bubble", 32'(v_o), 32'(1));
    end
    flush();

    // 4: backpressure
    drive(4'b1000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_gnt3", 32'(yumi_o), 32'(4'b1000));
    repeat (3) begin
      drive(4'b0011, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("t4_stall_gnt", 32'(yumi_o), 32'(0));
      chk("t4_stall_id", 32'(id_o), 32'(3));
    end
    drive(4'b0011, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_resume_gnt", 32'(yumi_o), 32'(4'b0001));
    drive('0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_new_id", 32'(id_o), 32'(0));
    chk("t4_next_gnt", 32'(yumi_o), 32'(4'b0010));
    flush();

    // 5: wrap and fairness
    drive(4'b1000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t5_gnt3", 32'(yumi_o), 32'(4'b1000));
    for (int i = 0; i < 3; i++) begin
      drive(4'b1001, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("t5_gnt", 32'(yumi_o), 32'((i == 1) ? 4'b1000 : 4'b0001));
    end
    flush();

    // 6: reset mid-operation
    drive('0, 1'b0, 1'b1, 1'b0);
    drive(4'b0010, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_gnt1", 32'(yumi_o), 32'(4'b0010));
    drive('0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_pend_v", 32'(v_o), 32'(1));
    chk("t6_pend_id", 32'(id_o), 32'(1));
    drive('0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t6_rst_gnt", 32'(yumi_o), 32'(0));
    drive(4'b1111, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_v_o", 32'(v_o), 32'(0));
    chk("t6_data_o", 32'(data_o), 32'(0));
    chk("t6_first_gnt", 32'(yumi_o), 32'(4'b0001));
    flush();

    // Random traffic with random backpressure and occasional resets
    repeat (400) begin
      drive(N'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
            $urandom_range(0, 99) == 0, 1'b1);
    end
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
